// File: rtl/dot_acc_pack_pkg.sv
// Shared definitions for the dot-product accumulate/pack block.
// Holds the default line/result widths, counter widths and the FSM
// state encoding so the top and its packer agree on them.
package dot_acc_pack_pkg;

    localparam int CACHE_WIDTH_DEF = 512;
    localparam int DATA_WIDTH_DEF  = 32;
    localparam int LPR_W           = 16;   // lines-per-row counter width
    localparam int ROWS_W          = 32;   // row counter width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } acc_state_t;

endpackage

// File: rtl/dot_acc_pack_packer.sv
// dot_line_packer: collects row results into a line-wide pack buffer and
// hands full (or final, partially filled) lines to a held output register.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clear             start of a new job: empty pack buffer, clear overflow
//   wr_en/wr_data     row result to place into the next free slot
//   wr_last           this row is the job's final row (forces a hand-off)
//   out_ack           consumer accepts out_line this cycle
//   out_line/out_valid  held output line
//   pack_pending      pack buffer is waiting to move to the output register
//   overflow          sticky: a row result arrived while the buffer was blocked
module dot_line_packer #(
    parameter int CACHE_WIDTH = 512,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   wr_en,
    input  logic                   wr_last,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   out_ack,
    output logic [CACHE_WIDTH-1:0] out_line,
    output logic                   out_valid,
    output logic                   pack_pending,
    output logic                   overflow
);

    localparam int SLOTS  = CACHE_WIDTH / DATA_WIDTH;
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    logic [CACHE_WIDTH-1:0] pack_buf;
    logic [SLOT_W-1:0]      slot;
    logic                   move;
    logic                   wr_ok;
    logic [SLOT_W-1:0]      wr_slot;
    logic                   slot_full;

    // A move empties the buffer on the same edge, so a row landing in the
    // move cycle goes into slot 0 of the fresh buffer instead of being
    // dropped; this keeps back-to-back strobes stall-free.
    assign move      = pack_pending && (!out_valid || out_ack);
    assign wr_ok     = wr_en && (!pack_pending || move);
    assign wr_slot   = move ? '0 : slot;
    assign slot_full = (wr_slot == SLOT_W'(SLOTS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_buf     <= '0;
            slot         <= '0;
            pack_pending <= 1'b0;
            overflow     <= 1'b0;
            out_line     <= '0;
            out_valid    <= 1'b0;
        end else if (clear) begin
            pack_buf     <= '0;
            slot         <= '0;
            pack_pending <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            if (move) begin
                out_line     <= pack_buf;
                out_valid    <= 1'b1;
                pack_buf     <= '0;        // zero-fill for the next line
                slot         <= '0;
                pack_pending <= 1'b0;
            end else if (out_valid && out_ack) begin
                out_valid <= 1'b0;
            end

            // Later non-blocking writes override the clear above.
            if (wr_ok) begin
                pack_buf[wr_slot*DATA_WIDTH +: DATA_WIDTH] <= wr_data;
                slot <= slot_full ? '0 : wr_slot + 1'b1;
                if (slot_full || wr_last) begin
                    pack_pending <= 1'b1;
                end
            end else if (wr_en) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dot_acc_pack.sv
// dot_acc_pack: accumulates L partial dot products per row, packs row
// results into cache-line-wide words and presents them with a
// valid/ack handshake. Upstream strobes cannot be backpressured.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle job start (honoured in IDLE only)
//   lines_per_row         partials per row (0 treated as 1), sampled on start
//   num_rows              rows in the job, sampled on start
//   in_valid/in_data      partial result strobe
//   out_line/out_valid    packed line, held until out_ack
//   out_ack               consumer accepts the line
//   busy                  job in progress
//   done                  one-cycle pulse after the final line is accepted
//   overflow              sticky row-drop indicator
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accumulating partials, writing row results to the packer
// FLUSH | all rows written, draining remaining line(s) to the consumer
module dot_acc_pack
    import dot_acc_pack_pkg::*;
#(
    parameter int CACHE_WIDTH = CACHE_WIDTH_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [LPR_W-1:0]       lines_per_row,
    input  logic [ROWS_W-1:0]      num_rows,
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic [CACHE_WIDTH-1:0] out_line,
    output logic                   out_valid,
    input  logic                   out_ack,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);

    acc_state_t state, next_state;

    logic [LPR_W-1:0]      l_reg;
    logic [ROWS_W-1:0]     r_reg;
    logic [DATA_WIDTH-1:0] acc;
    logic [LPR_W-1:0]      line_cnt;
    logic [ROWS_W-1:0]     row_cnt;

    logic                  start_job;
    logic                  run_strobe;
    logic                  row_end;
    logic                  final_row;
    logic [DATA_WIDTH-1:0] row_sum;
    logic                  pack_pending;
    logic                  last_ack;

    assign start_job  = (state == ST_IDLE) && start;
    assign run_strobe = (state == ST_RUN) && in_valid;
    assign row_sum    = acc + in_data;
    assign row_end    = run_strobe && ((line_cnt + 1'b1) == l_reg);
    assign final_row  = row_end && ((row_cnt + 1'b1) == r_reg);
    // Last line leaves only when nothing is queued behind it in the packer.
    assign last_ack   = (state == ST_FLUSH) && out_valid && out_ack && !pack_pending;
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start && (num_rows != '0)) next_state = ST_RUN;
            ST_RUN:   if (final_row)                 next_state = ST_FLUSH;
            ST_FLUSH: if (last_ack)                  next_state = ST_IDLE;
            default:                                 next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_reg    <= '0;
            r_reg    <= '0;
            acc      <= '0;
            line_cnt <= '0;
            row_cnt  <= '0;
            done     <= 1'b0;
        end else begin
            done <= (start_job && (num_rows == '0)) || last_ack;
            if (start_job) begin
                l_reg    <= (lines_per_row == '0) ? LPR_W'(1) : lines_per_row;
                r_reg    <= num_rows;
                acc      <= '0;
                line_cnt <= '0;
                row_cnt  <= '0;
            end else if (run_strobe) begin
                if (row_end) begin
                    acc      <= '0;
                    line_cnt <= '0;
                    row_cnt  <= row_cnt + 1'b1;   // counts dropped rows too
                end else begin
                    acc      <= row_sum;
                    line_cnt <= line_cnt + 1'b1;
                end
            end
        end
    end

    dot_line_packer #(
        .CACHE_WIDTH (CACHE_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (start_job),
        .wr_en        (row_end),
        .wr_last      (final_row),
        .wr_data      (row_sum),
        .out_ack      (out_ack),
        .out_line     (out_line),
        .out_valid    (out_valid),
        .pack_pending (pack_pending),
        .overflow     (overflow)
    );

endmodule

// File: tb/tb_dot_acc_pack.sv
module tb_dot_acc_pack;

    localparam int CW = 512;
    localparam int DW = 32;
    localparam int SL = CW / DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   lines_per_row = '0;
    logic [31:0]   num_rows = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] out_line;
    logic          out_valid;
    logic          out_ack = 1'b0;
    logic          busy;
    logic          done;
    logic          overflow;

    dot_acc_pack dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .lines_per_row (lines_per_row),
        .num_rows      (num_rows),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .out_line      (out_line),
        .out_valid     (out_valid),
        .out_ack       (out_ack),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int lines_seen = 0;

    // scoreboard of expected output lines
    logic [CW-1:0] exp_q[$];

    // reference model state
    int            m_l, m_r, m_cap, m_cnt, m_rows, m_slot;
    logic [DW-1:0] m_acc;
    logic [CW-1:0] m_line;

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Rows beyond m_cap are the ones the DUT is expected to drop.
    task automatic model_strobe(input logic [DW-1:0] d);
        if (m_rows < m_cap) begin
            m_acc = m_acc + d;
            m_cnt++;
            if (m_cnt == m_l) begin
                m_line[m_slot*DW +: DW] = m_acc;
                m_slot++;
                m_rows++;
                m_acc = '0;
                m_cnt = 0;
                if (m_slot == SL || m_rows == m_r) begin
                    exp_q.push_back(m_line);
                    m_line = '0;
                    m_slot = 0;
                end
            end
        end
    endtask

    task automatic begin_job(input int l, input int r);
        lines_per_row = 16'(l);
        num_rows      = 32'(r);
        m_l    = (l == 0) ? 1 : l;
        m_r    = r;
        m_cap  = r;
        m_cnt  = 0;
        m_rows = 0;
        m_slot = 0;
        m_acc  = '0;
        m_line = '0;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic strobe(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        model_strobe(d);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        int n = 0;
        while (done !== 1'b1 && n < max_cycles) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        assert (done === 1'b1) else begin
            errors++;
            $error("FAIL %s: done not seen within %0d cycles (observed %b expected 1)", tag, max_cycles, done);
        end
    endtask

    // Handshake is sampled on the falling edge; inputs only move #1 after rising edges.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ack) begin
            lines_seen++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_line: observed %0h expected no line", out_line);
            end
            if (exp_q.size() != 0) begin
                chk("line", out_line, exp_q.pop_front());
            end
        end
    end

    initial begin
        int ls0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_out_line", out_line, '0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // L=1, R=16, data 1..16 back-to-back, always acking
        out_ack = 1'b1;
        begin_job(1, 16);
        chk("t1_busy", busy, 1'b1);
        for (int k = 1; k <= 16; k++) strobe(32'(k));
        in_valid = 1'b0;
        chk("t1_no_early_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        chk("t1_valid_latency", out_valid, 1'b1);
        @(posedge clk); #1;
        chk("t1_done", done, 1'b1);
        chk("t1_busy_low", busy, 1'b0);
        @(posedge clk); #1;
        chk("t1_done_once", done, 1'b0);
        chk("t1_overflow", overflow, 1'b0);

        // L=4, R=3, data 2, gaps, a start ignored mid-run, delayed ack
        out_ack = 1'b0;
        begin_job(4, 3);
        for (int i = 0; i < 12; i++) begin
            strobe(32'd2);
            if (i == 5) begin
                start = 1'b1;
                num_rows = '0;
                idle();
                start = 1'b0;
            end
            if (i == 8) idle();
        end
        idle();
        repeat (3) idle();
        chk("t2_busy_wait", busy, 1'b1);
        chk("t2_valid_held", out_valid, 1'b1);
        chk("t2_no_done", done, 1'b0);
        out_ack = 1'b1;
        wait_done("t2_done", 10);
        chk("t2_busy_low", busy, 1'b0);
        chk("t2_overflow", overflow, 1'b0);

        // L=2 wrap
        begin_job(2, 1);
        strobe(32'hFFFF_FFFF);
        strobe(32'hFFFF_FFFF);
        idle();
        wait_done("t3_done", 10);

        // L=1, R=48 with no ack: row 33 onwards dropped
        out_ack = 1'b0;
        begin_job(1, 48);
        m_cap = 32;
        for (int k = 1; k <= 48; k++) strobe(32'(k));
        idle();
        chk("t4_overflow", overflow, 1'b1);
        chk("t4_valid", out_valid, 1'b1);
        chk("t4_busy", busy, 1'b1);
        chk("t4_slot0", out_line[31:0], 32'd1);
        repeat (5) idle();
        chk("t4_slot1_stable", out_line[63:32], 32'd2);
        ls0 = lines_seen;
        out_ack = 1'b1;
        wait_done("t4_done", 20);
        chk("t4_lines", 32'(lines_seen - ls0), 32'd2);
        chk("t4_overflow_sticky", overflow, 1'b1);

        // R=0: immediate done, never busy, overflow cleared by start
        begin_job(3, 0);
        chk("t5_done", done, 1'b1);
        chk("t5_busy", busy, 1'b0);
        chk("t5_overflow_clr", overflow, 1'b0);
        idle();
        chk("t5_done_once", done, 1'b0);
        chk("t5_no_valid", out_valid, 1'b0);

        // reset mid-row, then clean job right after release
        begin_job(4, 2);
        strobe(32'd5);
        strobe(32'd6);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy_async", busy, 1'b0);
        chk("t6_valid_async", out_valid, 1'b0);
        chk("t6_done_async", done, 1'b0);
        chk("t6_line_async", out_line, '0);
        chk("t6_overflow_async", overflow, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        begin_job(2, 2);
        chk("t6_first_start", busy, 1'b1);
        strobe(32'd3);
        strobe(32'd4);
        strobe(32'd5);
        strobe(32'd6);
        idle();
        wait_done("t6_done", 10);

        idle();
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d lines left expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
